// File: rtl/dual_port_fifo_ctrl.sv
// dual_port_fifo_ctrl: synchronous FIFO controller driving an external dual-port RAM.
// Tracks read/write pointers and occupancy; registers popped data from the RAM's d_out.
module dual_port_fifo_ctrl #(
  parameter int n = 4,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [m-1:0] wr_data,
  input  logic         rd_en,
  output logic [m-1:0] rd_data,
  output logic         rd_valid,
  output logic         full,
  output logic         empty,
  output logic [n:0]   count,
  output logic         overflow,
  output logic         underflow,
  output logic         ram_r,
  output logic         ram_w,
  output logic [n-1:0] ram_address_in,
  output logic [n-1:0] ram_address_out,
  output logic [m-1:0] ram_d_in,
  input  logic [m-1:0] ram_d_out
);
  logic [n-1:0] wptr, rptr;
  logic push_ok, pop_ok;
  // count never exceeds 2^n, so its top bit alone marks full
  assign full = count[n];
  assign empty = count == '0;
  // gating with rst_n keeps both RAM strobes low for the whole reset window
  assign push_ok = rst_n & wr_en & ~full;
  assign pop_ok = rst_n & rd_en & ~empty;
  assign ram_w = push_ok;
  assign ram_r = pop_ok;
  assign ram_address_in = wptr;
  assign ram_address_out = rptr;
  assign ram_d_in = wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
        rd_data <= ram_d_out;
      end
      rd_valid <= pop_ok;
      count <= count + (n+1)'(push_ok) - (n+1)'(pop_ok);
      if (wr_en & full) overflow <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end
endmodule

// File: doc/dual_port_fifo_ctrl.md
Name: dual_port_fifo_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator for the team's asynchronous-access dual_port RAM.
- Generates r, w, address_in, address_out and d_in for the RAM from a push/pop client interface, and captures the RAM's d_out.
- Sits between a producer and a consumer and provides full/empty/count status with sticky overflow/underflow flags.
- The RAM itself is external; this block only drives it and tracks pointers.

Parameters:
- n, 4, address width; FIFO depth = 2^n entries.
- m, 4, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request.
- wr_data  input  m  push data.
- rd_en  input  1  pop request.
- rd_data  output  m  popped data, registered.
- rd_valid  output  1  one-cycle strobe, rd_data valid.
- full  output  1  count == 2^n.
- empty  output  1  count == 0.
- count  output  n+1  current occupancy, 0..2^n.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- ram_r  output  1  to RAM r.
- ram_w  output  1  to RAM w.
- ram_address_in  output  n  RAM write address.
- ram_address_out  output  n  RAM read address.
- ram_d_in  output  m  RAM write data.
- ram_d_out  input  m  RAM read data (combinational from ram_address_out).

Behaviour:
- Reset (rst_n low, async): wptr=0, rptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0.
  - ram_w=0 and ram_r=0 while rst_n is low, regardless of requests.
- push_ok = wr_en & !full.
- pop_ok = rd_en & !empty.
- Both qualifiers use the registered count (no pass-through). A push into a full FIFO is rejected even if a pop occurs in the same cycle.
- RAM-side drive, all combinational:
  - ram_w = push_ok; ram_address_in = wptr; ram_d_in = wr_data.
  - ram_r = pop_ok; ram_address_out = rptr.
- On the clock edge:
  - If push_ok: wptr <= wptr+1, wrapping modulo 2^n (15 -> 0 for n=4).
  - If pop_ok: rptr <= rptr+1 (same wrap); rd_data <= ram_d_out; rd_valid <= 1.
  - If not pop_ok: rd_valid <= 0 and rd_data holds its value.
  - count <= count + push_ok - pop_ok.
  - Simultaneous push_ok and pop_ok: count unchanged, both pointers advance.
- Latency:
  - Pop: rd_data/rd_valid appear the cycle after the rd_en cycle.
  - Push: data is readable by a pop issued the cycle after the push edge. Empty deasserts after 1 edge.
- Hazard: a same-address read/write in one cycle is impossible, because pop requires !empty. Controller needs no bypass.
- Sticky flags:
  - overflow <= 1 when wr_en & full.
  - underflow <= 1 when rd_en & empty.
  - Both clear only on reset.
- Rejected requests change no pointer, no count, and no RAM strobe.
- Reset mid-operation: the FIFO empties immediately. Stored RAM contents are abandoned (not cleared) and are unreachable until rewritten.
- Order: strictly FIFO across pointer wrap-around.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, ram_w=0, ram_r=0, overflow=0, underflow=0.
- Push 0x0..0xF on 16 consecutive cycles -> ram_address_in steps 0..15, ram_w high each cycle, count=16, full=1. A 17th push with wr_data=0xA -> ram_w=0, overflow=1, count stays 16.
- From full, pop 16 times -> rd_data sequence 0x0..0xF, each one cycle after rd_en, rd_valid high 16 cycles, empty=1. A 17th pop -> ram_r=0, underflow=1, rd_valid=0.
- Wrap: push 10 and pop 10, then push 0x5, 0x6, 0x7 -> ram_address_in = 10, 11, 12. Continue 8 more pushes -> wrap to address 0. Popping returns 0x5, 0x6, 0x7 first, in order.
- Simultaneous push/pop with count=3 (data 0x1, 0x2, 0x3), push 0x9 -> count stays 3, rd_data=0x1, both pointers +1. Push plus pop while full -> pop accepted, push rejected, overflow=1, count=15.
- Assert rst_n low mid-cycle with count=7 -> count=0, empty=1, rd_valid=0 immediately (before the next edge). After release, push 0xC then pop -> rd_data=0xC.
